// File: rtl/trace_addr_streamer.sv
// trace_addr_streamer
//   Decodes a delta-encoded address trace and feeds the absolute addresses to
//   cache_controller. The first word after start is taken as an absolute address;
//   every later word is an unsigned delta added to the running address.
//   Decoded addresses are buffered in a small FIFO and presented on addr/rd_en,
//   popping whenever the cache signals cache_ready.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              one-cycle pulse, begins a trace (IDLE/DONE only)
//   in_valid/in_ready  trace word handshake
//   in_data, in_last   trace word and final-word marker
//   addr, rd_en        absolute address to cache and its valid
//   cache_ready        cache consumes addr when rd_en && cache_ready
//   issued             addresses consumed since start (saturating)
//   busy, done         RUN/DRAIN and DONE state indications
//   wrap               sticky carry-out of a delta addition
module trace_addr_streamer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  rd_en,
    input  logic                  cache_ready,
    output logic [31:0]           issued,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic [PtrW:0] OneCount  = (PtrW + 1)'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wptr_q, rptr_q;
    logic [PtrW:0]         count_q;

    logic [ADDR_WIDTH-1:0] acc_q;
    logic [ADDR_WIDTH-1:0] last_q;    // last popped address, shown while empty
    logic                  first_q;
    logic                  wrap_q;
    logic [31:0]           issued_q;

    logic                  fifo_empty, fifo_full;
    logic                  push, pop, start_ok;
    logic [ADDR_WIDTH:0]   sum;
    logic [ADDR_WIDTH-1:0] acc_next;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FullCount);

    // No full-bypass: a pop in the same cycle does not open in_ready.
    assign in_ready = (state_q == StRun) && !fifo_full;
    assign push     = in_valid && in_ready;
    assign pop      = !fifo_empty && cache_ready;
    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));

    assign sum      = {1'b0, acc_q} + {1'b0, in_data[ADDR_WIDTH-1:0]};
    assign acc_next = first_q ? in_data[ADDR_WIDTH-1:0] : sum[ADDR_WIDTH-1:0];

    // Head comes straight from registered storage; no path from in_data.
    assign rd_en  = !fifo_empty;
    assign addr   = fifo_empty ? last_q : mem_q[rptr_q];
    assign issued = issued_q;
    assign wrap   = wrap_q;
    assign busy   = (state_q == StRun) || (state_q == StDrain);
    assign done   = (state_q == StDone);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (push && in_last) state_d = StDrain;
            // DRAIN never pushes, so popping the single remaining entry empties the FIFO.
            StDrain: if (pop && (count_q == OneCount)) state_d = StDone;
            StDone:  if (start) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Storage array is not reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
                last_q <= mem_q[rptr_q];
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            first_q  <= 1'b1;
            wrap_q   <= 1'b0;
            issued_q <= '0;
        end else if (start_ok) begin
            // FIFO is already empty in IDLE/DONE, so only the decode state is cleared.
            acc_q    <= '0;
            first_q  <= 1'b1;
            wrap_q   <= 1'b0;
            issued_q <= '0;
        end else begin
            if (push) begin
                acc_q   <= acc_next;
                first_q <= 1'b0;
                if (!first_q && sum[ADDR_WIDTH]) begin
                    wrap_q <= 1'b1;
                end
            end
            if (pop && (issued_q != 32'hFFFF_FFFF)) begin
                issued_q <= issued_q + 32'd1;
            end
        end
    end

endmodule

// File: doc/trace_addr_streamer.md
Name: trace_addr_streamer

Overview:
- Upstream feeder for cache_controller.
- Accepts a delta-encoded address trace word-by-word over a valid/ready handshake. The first word after start is absolute; each later word is added to the running address.
- Buffers the decoded absolute addresses in a small FIFO and drives them onto the cache's addr/rd_en inputs, honouring a cache-side stall.
- Reports issue count, completion and address wrap-around.

Parameters:
- ADDR_WIDTH, 32, width of absolute address driven to the cache.
- DATA_WIDTH, 32, width of trace delta word; must be >= ADDR_WIDTH (upper bits above ADDR_WIDTH ignored).
- FIFO_DEPTH, 8, decoded-address buffer entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a new trace (honoured only in IDLE or DONE).
- in_valid  in  1  trace word valid.
- in_ready  out  1  streamer can accept trace word.
- in_data  in  DATA_WIDTH  trace word (absolute for first word, else unsigned delta).
- in_last  in  1  marks final trace word; qualified by in_valid && in_ready.
- addr  out  ADDR_WIDTH  absolute address to cache.
- rd_en  out  1  addr valid this cycle.
- cache_ready  in  1  cache consumes addr when rd_en && cache_ready.
- issued  out  32  count of addresses consumed by the cache since start; saturates at 32'hFFFF_FFFF.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- wrap  out  1  sticky: a delta addition carried out of ADDR_WIDTH.

Behaviour:
- Reset (rst_n low, async): state=IDLE, FIFO empty, accumulator=0, first flag=1, issued=0, wrap=0. Outputs: in_ready=0, rd_en=0, addr=0, busy=0, done=0.
- States:
  - IDLE: start -> RUN.
  - RUN: accepting words. Acceptance with in_last=1 -> DRAIN.
  - DRAIN: in_ready=0. When FIFO becomes empty (last pop) -> DONE. Same-cycle pop of final entry counts.
  - DONE: done=1. start -> RUN.
- start in IDLE/DONE: clears accumulator, sets first=1, clears issued and wrap; FIFO is already empty. start in RUN/DRAIN is ignored.
- in_ready = (state==RUN) && FIFO not full. No full-bypass: a same-cycle pop does not raise in_ready while full.
- On accept:
  - acc_next = first ? in_data[ADDR_WIDTH-1:0] : acc + in_data[ADDR_WIDTH-1:0], modulo 2^ADDR_WIDTH.
  - If the carry-out is set on a non-first word, set wrap.
  - Push acc_next into FIFO; clear first.
- Output side:
  - rd_en = FIFO not empty; addr = FIFO head, registered storage.
  - rd_en=0 implies addr holds its last value (0 after reset).
  - Pop when rd_en && cache_ready; issued increments on each pop, saturating.
- Latency: a word accepted at edge N appears on addr/rd_en after edge N (visible in cycle N+1) if the FIFO was empty. No combinational path from in_data to addr.
- Simultaneous push and pop: both occur; occupancy unchanged.
- rd_en holds and addr stays stable while cache_ready=0.
- Empty trace is not supported: the trace must contain >= 1 word with in_last.
- Reset asserted mid-trace: immediate return to reset values. FIFO contents are discarded; pointers reset, data need not clear.

Test Plan:
- Basic decode: start, feed 100, 4, 4, 0xFFFFFFF8(last), cache_ready=1 -> addr sequence 100, 104, 108, 100; issued=4; done=1; wrap=1 (last add carries).
- Backpressure fill: cache_ready=0, stream 12 words -> in_ready drops after 8 accepts; rd_en=1 with addr = first word held stable. Raise cache_ready -> all 12 addresses issue in order; issued=12.
- Full with simultaneous pop: FIFO at 8 entries, cache_ready=1 for one cycle with in_valid=1 -> one pop, no push that cycle; in_ready rises next cycle.
- Drain/done: last word accepted while 3 entries queued -> busy=1, in_ready=0 until FIFO empties; done asserts the cycle after final pop; second start resets issued=0, wrap=0, first word treated absolute.
- Start ignored mid-run: pulse start in RUN -> no change to accumulator, issued or FIFO.
- Async reset mid-trace: drop rst_n between clock edges with 5 entries queued -> rd_en=0, in_ready=0, issued=0, state IDLE immediately, without waiting for a clock edge.
